// File: rtl/hex_reverse_stream.sv
// hex_reverse_stream
//   Streaming digit/bit re-orderer. A word is accepted over a valid/ready
//   handshake and then processed by a serial engine, one digit per cycle. The
//   finished result is queued in a small output FIFO. While the FIFO has room,
//   downstream back-pressure does not stop the engine from taking new words.
//
//   Modes (in_mode, latched with each word):
//     00 passthrough
//     01 digit reverse
//     10 bit reverse inside each digit
//     11 full bit reverse
//
// Ports
//   clk, rst   rising-edge clock, synchronous active-high reset
//   in_valid   input word valid
//   in_ready   engine idle and not in reset
//   in_data    SIZE-bit input word; digit k = in_data[k*DIGIT_W +: DIGIT_W]
//   in_mode    2-bit mode, captured on accept
//   out_valid  FIFO not empty
//   out_ready  downstream accepts the head word
//   out_data   FIFO head word, or 0 when the FIFO is empty
//   level      FIFO occupancy
//   busy       engine not idle
module hex_reverse_stream #(
   parameter int DIGITS     = 4,
   parameter int DIGIT_W    = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int SIZE      = DIGITS * DIGIT_W,
   localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] in_data,
   input  logic [1:0]      in_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] out_data,
   output logic [LW-1:0]   level,
   output logic            busy
);

   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [SIZE-1:0]   src_q, src_d;
   logic [1:0]        mode_q, mode_d;
   logic [SIZE-1:0]   res_q, res_d;
   logic [PW-1:0]     wr_q, wr_d;
   logic [PW-1:0]     rd_q, rd_d;
   logic [LW-1:0]     count_q, count_d;
   logic [SIZE-1:0]   mem_q [FIFO_DEPTH];

   logic              full;
   logic              push;
   logic              pop;
   logic [DIGIT_W-1:0] src_dig;
   logic [DIGIT_W-1:0] out_dig;
   int                 pos;

   // Full looks only at the registered count, so a push in the same cycle
   // as a pop on a full FIFO is refused and retried next cycle.
   assign full      = (count_q == LW'(FIFO_DEPTH));
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready;
   assign out_data  = out_valid ? mem_q[rd_q] : '0;
   assign level     = count_q;
   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == IDLE) & ~rst;

   // Digit selected this SHIFT cycle, its optional bit reversal and its
   // destination slot.
   always_comb begin
      src_dig = src_q[int'(cnt_q)*DIGIT_W +: DIGIT_W];
      out_dig = src_dig;
      if (mode_q[1]) begin
         for (int b = 0; b < DIGIT_W; b++) out_dig[b] = src_dig[DIGIT_W-1-b];
      end
      pos = mode_q[0] ? (DIGITS - 1 - int'(cnt_q)) : int'(cnt_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      mode_d  = mode_q;
      res_d   = res_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               src_d   = in_data;
               mode_d  = in_mode;
               cnt_d   = '0;
               res_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            res_d[pos*DIGIT_W +: DIGIT_W] = out_dig;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DIGITS - 1)) state_d = PUSH;
         end
         PUSH: begin
            if (!full) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_d    = push ? wr_q + PW'(1) : wr_q;
      rd_d    = pop  ? rd_q + PW'(1) : rd_q;
      count_d = count_q;
      if (push && !pop)      count_d = count_q + LW'(1);
      else if (!push && pop) count_d = count_q - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         mode_q  <= '0;
         res_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         mode_q  <= mode_d;
         res_q   <= res_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: out_data is gated by out_valid.
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_q] <= res_q;
   end

endmodule

// File: tb/tb_hex_reverse_stream.sv
module tb_hex_reverse_stream;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [15:0] in_data, out_data;
   logic [1:0]  in_mode;
   logic [2:0]  level;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [31:0] in_data8, out_data8;
   logic [1:0]  in_mode8;
   logic [2:0]  level8;

   hex_reverse_stream #(.DIGITS(4), .DIGIT_W(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .level(level), .busy(busy));

   hex_reverse_stream #(.DIGITS(8), .DIGIT_W(4), .FIFO_DEPTH(4)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data8), .in_mode(in_mode8), .out_valid(out_valid8),
      .out_ready(out_ready8), .out_data(out_data8), .level(level8), .busy(busy8));

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_q[$];
   bit          rnd_en = 1'b0;

   // Reference: split into hex digits, optionally mirror each digit's bits,
   // optionally reverse the digit list, reassemble.
   function automatic logic [63:0] model(input logic [63:0] w, input logic [1:0] m, input int nd);
      logic [3:0]  dg[$];
      logic [3:0]  d;
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < nd; k++) begin
         d = w[k*4 +: 4];
         if (m[1]) d = {d[0], d[1], d[2], d[3]};
         dg.push_back(d);
      end
      if (m[0]) dg.reverse();
      for (int k = 0; k < nd; k++) r[k*4 +: 4] = dg[k];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Present one word; returns one step after the accepting edge.
   task automatic send(input logic [15:0] data, input logic [1:0] mode);
      int n;
      in_data  = data;
      in_mode  = mode;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(16'(model(64'(data), mode, 4)));
      tick();
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_mode  = 2'($urandom);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard monitor: a word leaves the FIFO at the next edge whenever
   // out_valid & out_ready hold at the falling edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got %0h expected none", out_data);
         end else begin
            chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int lat;
      logic [15:0] w[5];
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mode = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; in_data8 = '0; in_mode8 = '0;
      tick(); tick();
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_level", 64'(level), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_out_data", 64'(out_data), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 1);

      // 1: digit reverse, latency
      out_ready = 1'b1;
      send(16'habcd, 2'b01);
      chk("t1_model", model(64'h abcd, 2'b01, 4), 64'hdcba);
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      chk("t1_latency", 64'(lat), 5);
      chk("t1_data", 64'(out_data), 64'hdcba);
      tick(); tick();

      // 2: back-to-back, in_ready low for 5 cycles
      send(16'habcd, 2'b10);
      for (int i = 0; i < 5; i++) begin
         chk("t2_in_ready_low", 64'(in_ready), 0);
         tick();
      end
      chk("t2_in_ready_high", 64'(in_ready), 1);
      send(16'hacef, 2'b11);
      chk("t2_model_a", model(64'habcd, 2'b10, 4), 64'h5d3b);
      chk("t2_model_b", model(64'hacef, 2'b11, 4), 64'hf735);
      drain(40);

      // 3: passthrough, same latency
      send(16'h1234, 2'b00);
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      chk("t3_latency", 64'(lat), 5);
      chk("t3_data", 64'(out_data), 64'h1234);
      drain(40);

      // 4: back-pressure, stall in PUSH, order preserved
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w[i] = 16'($urandom);
         send(w[i], 2'(i));
      end
      for (int i = 0; i < 8; i++) tick();
      chk("t4_level_full", 64'(level), 4);
      chk("t4_busy", 64'(busy), 1);
      chk("t4_in_ready", 64'(in_ready), 0);
      chk("t4_hold", 64'(out_data), model(64'(w[0]), 2'd0, 4));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t4_level_after_pop", 64'(level), 3);
      chk("t4_still_busy", 64'(busy), 1);
      tick();
      chk("t4_level_refill", 64'(level), 4);
      chk("t4_idle", 64'(busy), 0);
      out_ready = 1'b1;
      drain(40);

      // 5: reset mid-SHIFT with two words queued
      out_ready = 1'b0;
      send(16'h1111, 2'b01);
      send(16'h2222, 2'b10);
      lat = 0;
      while (level != 3'd2 && lat < 30) begin tick(); lat++; end
      chk("t5_level2", 64'(level), 2);
      send(16'h3333, 2'b11);
      tick();
      chk("t5_busy_shift", 64'(busy), 1);
      rst = 1'b1;
      tick();
      chk("t5_level", 64'(level), 0);
      chk("t5_out_valid", 64'(out_valid), 0);
      chk("t5_busy", 64'(busy), 0);
      chk("t5_in_ready_rst", 64'(in_ready), 0);
      exp_q.delete();
      rst = 1'b0;
      #1;
      chk("t5_in_ready", 64'(in_ready), 1);
      tick();

      // 6: eight-digit instance
      in_data8 = 32'h01234567; in_mode8 = 2'b01; in_valid8 = 1'b1;
      chk("t6_ready", 64'(in_ready8), 1);
      tick();
      in_valid8 = 1'b0;
      chk("t6_busy", 64'(busy8), 1);
      lat = 0;
      while (!out_valid8 && lat < 30) begin tick(); lat++; end
      chk("t6_latency", 64'(lat), 9);
      chk("t6_data", 64'(out_data8), 64'h76543210);
      chk("t6_model", model(64'h01234567, 2'b01, 8), 64'h76543210);
      tick();

      // randomized traffic with random back-pressure
      rnd_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send(16'($urandom), 2'($urandom));
         if ($urandom_range(0, 3) == 0) tick();
      end
      drain(2000);
      rnd_en = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      chk("final_level", 64'(level), 0);
      chk("final_level8", 64'(level8), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
